// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with fixed access latency,
// byte/half/word store lanes, sign/zero-extended loads and bad-access flagging.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d, uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
    logic        err, wr_en;
    logic [3:0]  be;
    logic [31:0] rd_word, wlane, ld;
    logic [15:0] lane;

    always_comb begin
        err     = (size_q == 2'b11) || (size_q == 2'b01 && addr_q[0]) ||
                  (size_q == 2'b10 && addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * DEPTH_WORDS));
        wr_en   = state_q == ACCESS && !err && we_q && !reset;
        be      = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                  size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wlane   = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                  size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
        rd_word = mem[addr_q[AW+1:2]];
        lane    = 16'(rd_word >> {addr_q[1:0], 3'b000});
        ld      = size_q == 2'b00 ? {{24{!uns_q && lane[7]}}, lane[7:0]} :
                  size_q == 2'b01 ? {{16{!uns_q && lane[15]}}, lane[15:0]} : rd_word;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                we_d        = req_we;
                uns_d       = req_unsigned;
                size_d      = req_size;
                addr_d      = req_addr;
                wdata_d     = req_wdata;
                cnt_d       = 4'(LATENCY);
                req_ready_d = 1'b0;
                if (LATENCY == 0) state_d = ACCESS;
                else state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ACCESS;
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err;
                rsp_rdata_d = (err || we_q) ? 32'd0 : ld;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, corner sequences and random traffic against a byte-array model.
module tb_dmem_responder;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 0, reset = 1;
    logic        req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 1;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        d0_req_valid = 0, d0_rsp_ready = 1;
    logic        d0_req_ready, d0_rsp_valid, d0_rsp_err;
    logic [31:0] d0_rsp_rdata;

    int total = 0, bad = 0;
    logic [7:0] ref_mem [4*DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) d0 (
        .clk(clk), .reset(reset), .req_valid(d0_req_valid), .req_ready(d0_req_ready),
        .req_we(1'b0), .req_size(2'b10), .req_unsigned(1'b0),
        .req_addr(32'h0), .req_wdata(32'h0), .rsp_valid(d0_rsp_valid),
        .rsp_ready(d0_rsp_ready), .rsp_rdata(d0_rsp_rdata), .rsp_err(d0_rsp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a, wd, rd;
        logic        er;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Byte-addressed model: n = 2**size bytes, little-endian, two's-complement extension.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int n;
        longint v;
        n  = 1 << sz;
        er = (sz == 2'b11) || ((a % 32'(n)) != 0) || (a >= 32'(4 * DEPTH));
        rd = 0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8 * i));
            if (!uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
            rd = v[31:0];
        end
    endfunction

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1; rsp_ready = 1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, mrd, a;
        logic        er, mer, we, uns;
        logic [1:0]  sz;
        int          lat, n, last, cnt;
        for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;

        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 2'd0, 1'b0, 32'h11,       32'h00000080, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b0, 32'h11,       32'h0,        32'hFFFFFF80, 1'b0});
        tbl.push_back('{1'b0, 2'd0, 1'b1, 32'h11,       32'h0,        32'h00000080, 1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hDEAD80EF, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h13,       32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h12,       32'h12345678, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'd3, 1'b0, 32'h10,       32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 2'd2, 1'b0, 32'h1000,     32'h12345678, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hDEAD80EF, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b0, 32'h12,       32'h0,        32'hFFFFDEAD, 1'b0});
        tbl.push_back('{1'b0, 2'd1, 1'b1, 32'h10,       32'h0,        32'h000080EF, 1'b0});
        tbl.push_back('{1'b1, 2'd1, 1'b0, 32'h12,       32'hAAAA5555, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'h555580EF, 1'b0});
        tbl.push_back('{1'b0, 2'd3, 1'b1, 32'h0,        32'h0,        32'h0,        1'b1});

        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_d0_ready", 32'(d0_req_ready), 32'd1);

        foreach (tbl[i]) begin
            xact(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, rd, er, lat);
            model(tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, mrd, mer);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(LAT + 2));
        end

        // Response held back: outputs stable, second request ignored.
        @(negedge clk);
        req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h10; req_valid = 1; rsp_ready = 0;
        @(posedge clk);
        #1 req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        chk("hold_lat", 32'(n), 32'(LAT + 2));
        req_we = 1; req_wdata = 32'h0; req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, 32'h555580EF);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 0; rsp_ready = 1;
        @(negedge clk);
        chk("hold_drop_valid", 32'(rsp_valid), 32'd0);
        chk("hold_ready_back", 32'(req_ready), 32'd1);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("hold_ignored", rd, 32'h555580EF);

        // Reset during WAIT of a word store must not write.
        @(negedge clk);
        req_we = 1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h11111111; req_valid = 1;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("midrst_nowrite", rd, 32'h555580EF);

        for (int k = 0; k < 150; k++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = 32'(4 * DEPTH - 4 + $urandom_range(0, 7));
                1: a = $urandom;
                default: a = 32'($urandom_range(0, 47));
            endcase
            xact(we, sz, uns, a, $urandom, rd, er, lat);
            model(we, sz, uns, a, req_wdata, mrd, mer);
            chk($sformatf("rnd%0d_rdata a=%h sz=%0d we=%0d", k, a, sz, we), rd, mrd);
            chk($sformatf("rnd%0d_err", k), 32'(er), 32'(mer));
            chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'(LAT + 2));
        end

        // Zero-latency instance: back-to-back requests give one response every 3 cycles.
        @(negedge clk);
        d0_req_valid = 1; d0_rsp_ready = 1;
        last = -1; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (d0_rsp_valid) begin
                if (last >= 0) chk("b2b_gap", 32'(i - last), 32'd3);
                chk("b2b_req_ready_low", 32'(d0_req_ready), 32'd0);
                chk("b2b_rdata", d0_rsp_rdata, 32'd0);
                last = i;
                cnt++;
            end
        end
        d0_req_valid = 0;
        chk("b2b_count", 32'(cnt), 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
